// File: rtl/avalon_bram_arbiter_if.sv
// Avalon-MM bus bundle used on each side of avalon_bram_arbiter.
//   master modport : drives address/byteenable/read/write/writedata,
//                    receives readdata/readdatavalid/waitrequest.
//   slave modport  : the mirror image.
// The arbiter takes two slave-side bundles (m0, m1) and one master-side
// bundle (s) towards the BRAM.
interface avalon_bram_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_bram_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter for a fixed-latency slave (BRAM).
// Round-robin between m0 and m1, with the grant locked while the slave
// stalls; a tag pipeline steers readdatavalid back to the issuing master.
// Ports:
//   clock, reset      : clock and asynchronous active-low reset
//   m0, m1            : master-facing buses (slave modport)
//   s                 : slave-facing bus (master modport)
//   stall_cycles      : saturating count of cycles a requester lost arbitration
module avalon_bram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  avalon_bram_arbiter_if.slave   m0,
  avalon_bram_arbiter_if.slave   m1,
  avalon_bram_arbiter_if.master  s,
  output logic [COUNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic {LK_FREE, LK_HELD} lock_e;

  lock_e                   lock_q, lock_d;
  logic                    lock_id_q, lock_id_d;
  logic                    prio_q, prio_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;
  logic [COUNT_WIDTH-1:0]  stall_q, stall_d;

  logic                    req0, req1;
  logic                    gnt_vld, gnt_id;
  logic                    accept, contend;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q    <= LK_FREE;
      lock_id_q <= 1'b0;
      prio_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      stall_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    prio_d    = prio_q;
    if (accept) begin
      prio_d = ~gnt_id;
      lock_d = LK_FREE;
    end else if (gnt_vld && s.waitrequest) begin
      lock_d    = LK_HELD;
      lock_id_d = gnt_id;
    end

    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = accept & s.read;
    tag_id_d[0]  = gnt_id;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    stall_d = stall_q;
    if (contend && (stall_q != '1)) begin
      stall_d = stall_q + COUNT_WIDTH'(1);
    end
  end

  // Output logic: grant selection and slave mux. Grant is forced off while
  // reset is asserted so the slave sees no command and masters see waitrequest.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (reset) begin
      if (lock_q == LK_HELD) begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id_q;
      end else if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (req0) begin
        gnt_vld = 1'b1;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    sel_addr  = gnt_id ? m1.address   : m0.address;
    sel_wdata = gnt_id ? m1.writedata : m0.writedata;
    contend   = (req0 && !(gnt_vld && !gnt_id)) || (req1 && !(gnt_vld && gnt_id));
  end

  assign s.address      = sel_addr;
  assign s.writedata    = sel_wdata;
  assign s.byteenable   = gnt_id ? m1.byteenable : m0.byteenable;
  assign s.read         = gnt_vld & (gnt_id ? m1.read  : m0.read);
  assign s.write        = gnt_vld & (gnt_id ? m1.write : m0.write);
  assign accept         = (s.read | s.write) & ~s.waitrequest;

  assign m0.waitrequest = ~(gnt_vld & ~gnt_id) | s.waitrequest;
  assign m1.waitrequest = ~(gnt_vld &  gnt_id) | s.waitrequest;

  assign m0.readdatavalid = tag_vld_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
  assign m1.readdatavalid = tag_vld_q[READ_LATENCY-1] &  tag_id_q[READ_LATENCY-1];
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;

  assign stall_cycles = stall_q;

  a_m0_rw_excl: assert property (@(posedge clock) disable iff (!reset) !(m0.read && m0.write))
    else $error("m0 asserted read and write together");
  a_m1_rw_excl: assert property (@(posedge clock) disable iff (!reset) !(m1.read && m1.write))
    else $error("m1 asserted read and write together");

endmodule

// File: tb/tb_avalon_bram_arbiter.sv
// Self-checking bench for avalon_bram_arbiter. Two instances:
//   dut_a : READ_LATENCY=1, COUNT_WIDTH=16
//   dut_b : READ_LATENCY=3, COUNT_WIDTH=4
// Each drives a behavioural BRAM; expected read returns are queued per
// instance when stimulus is driven and popped when readdatavalid appears.
`timescale 1ns/1ps
module tb_avalon_bram_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct {
    int unsigned    due;
    logic           id;
    logic [DW-1:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        swr_a, swr_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  logic [DW-1:0]  mem_a [0:255];
  logic [DW-1:0]  mem_b [0:255];
  logic [255:0]   wr_a = '0;
  logic [255:0]   wr_b = '0;
  logic [DW-1:0]  rp_a;
  logic [DW-1:0]  rp_b [0:2];

  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia_m0 ();
  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia_m1 ();
  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia_s ();
  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib_m0 ();
  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib_m1 ();
  avalon_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib_s ();

  avalon_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .COUNT_WIDTH(16)) dut_a (
    .clock(clk), .reset(rst_a), .m0(ia_m0), .m1(ia_m1), .s(ia_s), .stall_cycles(stall_a)
  );
  avalon_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .COUNT_WIDTH(4)) dut_b (
    .clock(clk), .reset(rst_b), .m0(ib_m0), .m1(ib_m1), .s(ib_s), .stall_cycles(stall_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {18'd0, a};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] peek_a(input logic [AW-1:0] a);
    return wr_a[a[7:0]] ? mem_a[a[7:0]] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] peek_b(input logic [AW-1:0] a);
    return wr_b[a[7:0]] ? mem_b[a[7:0]] : init_word(a);
  endfunction

  // Behavioural BRAMs: registered read of the presented address, delayed
  // to the configured latency; writes land when not stalled.
  always @(posedge clk) begin
    rp_a <= peek_a(ia_s.address);
    if (ia_s.write && !swr_a) begin
      mem_a[ia_s.address[7:0]] <= merge(peek_a(ia_s.address), ia_s.writedata, ia_s.byteenable);
      wr_a[ia_s.address[7:0]]  <= 1'b1;
    end
    rp_b[0] <= peek_b(ib_s.address);
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
    if (ib_s.write && !swr_b) begin
      mem_b[ib_s.address[7:0]] <= merge(peek_b(ib_s.address), ib_s.writedata, ib_s.byteenable);
      wr_b[ib_s.address[7:0]]  <= 1'b1;
    end
  end

  assign ia_s.readdata      = rp_a;
  assign ia_s.waitrequest   = swr_a;
  assign ia_s.readdatavalid = 1'b0;
  assign ib_s.readdata      = rp_b[2];
  assign ib_s.waitrequest   = swr_b;
  assign ib_s.readdatavalid = 1'b0;

  // Scoreboard monitors: every readdatavalid must match the queue head due now.
  always @(negedge clk) begin : mon_a
    exp_t e;
    bit   have;
    have = (qa.size() > 0) && (qa[0].due == cyc);
    e = '{due: 0, id: 1'b0, data: '0};
    if (have) e = qa.pop_front();
    if (have || ia_m0.readdatavalid || ia_m1.readdatavalid) begin
      n_cmp++;
      if (!have) begin
        n_err++;
        $display("FAIL a_unexpected_rdv cyc=%0d: rdv0=%b rdv1=%b, required none", cyc,
                 ia_m0.readdatavalid, ia_m1.readdatavalid);
      end else if ({ia_m0.readdatavalid, ia_m1.readdatavalid} !== (e.id ? 2'b01 : 2'b10) ||
                   (e.id ? ia_m1.readdata : ia_m0.readdata) !== e.data) begin
        n_err++;
        $display("FAIL a_read_return cyc=%0d: rdv0=%b rdv1=%b data=%h, required master%0d data=%h",
                 cyc, ia_m0.readdatavalid, ia_m1.readdatavalid, ia_m0.readdata, e.id, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    bit   have;
    have = (qb.size() > 0) && (qb[0].due == cyc);
    e = '{due: 0, id: 1'b0, data: '0};
    if (have) e = qb.pop_front();
    if (have || ib_m0.readdatavalid || ib_m1.readdatavalid) begin
      n_cmp++;
      if (!have) begin
        n_err++;
        $display("FAIL b_unexpected_rdv cyc=%0d: rdv0=%b rdv1=%b, required none", cyc,
                 ib_m0.readdatavalid, ib_m1.readdatavalid);
      end else if ({ib_m0.readdatavalid, ib_m1.readdatavalid} !== (e.id ? 2'b01 : 2'b10) ||
                   (e.id ? ib_m1.readdata : ib_m0.readdata) !== e.data) begin
        n_err++;
        $display("FAIL b_read_return cyc=%0d: rdv0=%b rdv1=%b data=%h, required master%0d data=%h",
                 cyc, ib_m0.readdatavalid, ib_m1.readdatavalid, ib_m0.readdata, e.id, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit inst, input bit id, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    case ({inst, id})
      2'b00: begin ia_m0.read = rd; ia_m0.write = wr; ia_m0.address = addr; ia_m0.writedata = wd; ia_m0.byteenable = 4'hF; end
      2'b01: begin ia_m1.read = rd; ia_m1.write = wr; ia_m1.address = addr; ia_m1.writedata = wd; ia_m1.byteenable = 4'hF; end
      2'b10: begin ib_m0.read = rd; ib_m0.write = wr; ib_m0.address = addr; ib_m0.writedata = wd; ib_m0.byteenable = 4'hF; end
      default: begin ib_m1.read = rd; ib_m1.write = wr; ib_m1.address = addr; ib_m1.writedata = wd; ib_m1.byteenable = 4'hF; end
    endcase
  endtask

  task automatic idle(input bit inst);
    set_m(inst, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(inst, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; swr_a = 1'b0; swr_b = 1'b0;
    idle(1'b0); idle(1'b1);
    repeat (2) step();
    set_m(1'b0, 1'b0, 1'b1, 1'b0, 14'h010, '0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 14'h011, '0);
    @(negedge clk);
    n_cmp++;
    if ({ia_m0.waitrequest, ia_m1.waitrequest, ib_m0.waitrequest, ib_m1.waitrequest} !== 4'hF) begin
      n_err++; $display("FAIL reset_waitrequest: got %b, required 1111",
        {ia_m0.waitrequest, ia_m1.waitrequest, ib_m0.waitrequest, ib_m1.waitrequest});
    end
    n_cmp++;
    if ({ia_s.read, ia_s.write, ib_s.read, ib_s.write} !== 4'h0) begin
      n_err++; $display("FAIL reset_slave_cmd: got %b, required 0000",
        {ia_s.read, ia_s.write, ib_s.read, ib_s.write});
    end
    n_cmp++;
    if ({ia_m0.readdatavalid, ia_m1.readdatavalid, ib_m0.readdatavalid, ib_m1.readdatavalid} !== 4'h0) begin
      n_err++; $display("FAIL reset_rdv: got %b, required 0000",
        {ia_m0.readdatavalid, ia_m1.readdatavalid, ib_m0.readdatavalid, ib_m1.readdatavalid});
    end
    n_cmp++;
    if (stall_a !== 16'h0 || stall_b !== 4'h0) begin
      n_err++; $display("FAIL reset_stall: got %h/%h, required 0/0", stall_a, stall_b);
    end
    idle(1'b0); idle(1'b1);
    step();
    rst_a = 1'b1; rst_b = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({ia_m0.waitrequest, ia_m1.waitrequest} !== 2'b11 || stall_a !== 16'h0) begin
      n_err++; $display("FAIL idle_after_reset: got wr=%b stall=%h, required wr=11 stall=0",
        {ia_m0.waitrequest, ia_m1.waitrequest}, stall_a);
    end
  endtask

  task automatic test_single_read();
    step();
    set_m(1'b0, 1'b0, 1'b1, 1'b0, 14'h010, '0);
    qa.push_back('{cyc + 1, 1'b0, init_word(14'h010)});
    @(negedge clk);
    n_cmp++;
    if (ia_m0.waitrequest !== 1'b0 || ia_m1.waitrequest !== 1'b1 || ia_s.read !== 1'b1 ||
        ia_s.write !== 1'b0 || ia_s.address !== 14'h010) begin
      n_err++; $display("FAIL single_grant: got wr0=%b wr1=%b rd=%b wr=%b addr=%h, required 0 1 1 0 010",
        ia_m0.waitrequest, ia_m1.waitrequest, ia_s.read, ia_s.write, ia_s.address);
    end
    step();
    idle(1'b0);
    @(negedge clk);
    n_cmp++;
    if (ia_m0.readdatavalid !== 1'b1 || ia_m1.readdatavalid !== 1'b0 || ia_m0.readdata !== init_word(14'h010)) begin
      n_err++; $display("FAIL single_return: got rdv0=%b rdv1=%b data=%h, required 1 0 %h",
        ia_m0.readdatavalid, ia_m1.readdatavalid, ia_m0.readdata, init_word(14'h010));
    end
    step();
  endtask

  task automatic test_alternate();
    logic w;
    step();
    set_m(1'b0, 1'b0, 1'b1, 1'b0, 14'h001, '0);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 14'h002, '0);
    // m0 was the last master accepted, so m1 holds priority first.
    for (int i = 0; i < 6; i++) begin
      w = (i % 2 == 0);
      qa.push_back('{cyc + 1, w, init_word(w ? 14'h002 : 14'h001)});
      @(negedge clk);
      n_cmp++;
      if ({ia_m0.waitrequest, ia_m1.waitrequest} !== (w ? 2'b10 : 2'b01) ||
          ia_s.address !== (w ? 14'h002 : 14'h001)) begin
        n_err++; $display("FAIL alt_grant[%0d]: got wr=%b addr=%h, required winner m%0d", i,
          {ia_m0.waitrequest, ia_m1.waitrequest}, ia_s.address, w);
      end
      n_cmp++;
      if (stall_a !== 16'(i)) begin
        n_err++; $display("FAIL alt_stall[%0d]: got %0d, required %0d", i, stall_a, i);
      end
      step();
    end
    idle(1'b0);
    @(negedge clk);
    n_cmp++;
    if (stall_a !== 16'd6) begin
      n_err++; $display("FAIL alt_stall_final: got %0d, required 6", stall_a);
    end
    repeat (2) step();
  endtask

  task automatic test_lock();
    step();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 14'h003, '0);  // leaves prio on m0
    qa.push_back('{cyc + 1, 1'b1, init_word(14'h003)});
    step();
    swr_a = 1'b1;
    set_m(1'b0, 1'b1, 1'b0, 1'b1, 14'h020, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_m(1'b0, 1'b0, 1'b1, 1'b0, 14'h030, '0);
      @(negedge clk);
      n_cmp++;
      if (ia_s.write !== 1'b1 || ia_s.read !== 1'b0 || ia_s.address !== 14'h020 ||
          ia_s.writedata !== 32'hDEAD_BEEF || {ia_m0.waitrequest, ia_m1.waitrequest} !== 2'b11) begin
        n_err++; $display("FAIL lock_hold[%0d]: got wr=%b rd=%b addr=%h wd=%h wreq=%b, required locked m1 write", i,
          ia_s.write, ia_s.read, ia_s.address, ia_s.writedata, {ia_m0.waitrequest, ia_m1.waitrequest});
      end
      step();
    end
    swr_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ia_m0.waitrequest, ia_m1.waitrequest} !== 2'b10 || ia_s.write !== 1'b1 || ia_s.address !== 14'h020) begin
      n_err++; $display("FAIL lock_accept: got wreq=%b wr=%b addr=%h, required 10 1 020",
        {ia_m0.waitrequest, ia_m1.waitrequest}, ia_s.write, ia_s.address);
    end
    step();
    set_m(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    qa.push_back('{cyc + 1, 1'b0, init_word(14'h030)});
    @(negedge clk);
    n_cmp++;
    if (ia_m0.waitrequest !== 1'b0 || ia_s.read !== 1'b1 || ia_s.address !== 14'h030) begin
      n_err++; $display("FAIL lock_next_grant: got wreq0=%b rd=%b addr=%h, required 0 1 030",
        ia_m0.waitrequest, ia_s.read, ia_s.address);
    end
    step();
    set_m(1'b0, 1'b0, 1'b1, 1'b0, 14'h020, '0);
    qa.push_back('{cyc + 1, 1'b0, 32'hDEAD_BEEF});
    step();
    idle(1'b0);
    repeat (2) step();
    n_cmp++;
    if (qa.size() != 0) begin
      n_err++; $display("FAIL a_queue_drained: got %0d pending, required 0", qa.size());
    end
  endtask

  task automatic test_interleave_rl3();
    step();
    set_m(1'b1, 1'b0, 1'b1, 1'b0, 14'h005, '0);
    qb.push_back('{cyc + 3, 1'b0, init_word(14'h005)});
    step();
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b1, 1'b0, 1'b1, 14'h006, 32'h1234_5678);
    step();
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 14'h007, '0);
    qb.push_back('{cyc + 3, 1'b1, init_word(14'h007)});
    step();
    idle(1'b1);
    @(negedge clk);
    n_cmp++;
    if (ib_m0.readdatavalid !== 1'b1) begin
      n_err++; $display("FAIL rl3_m0_at_t3: got %b, required 1", ib_m0.readdatavalid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({ib_m0.readdatavalid, ib_m1.readdatavalid} !== 2'b00) begin
      n_err++; $display("FAIL rl3_write_slot: got %b, required 00", {ib_m0.readdatavalid, ib_m1.readdatavalid});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (ib_m1.readdatavalid !== 1'b1) begin
      n_err++; $display("FAIL rl3_m1_at_t5: got %b, required 1", ib_m1.readdatavalid);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_midflight();
    step();
    set_m(1'b1, 1'b0, 1'b1, 1'b0, 14'h008, '0);
    step();
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 14'h009, '0);
    step();
    idle(1'b1);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst_b = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ib_m0.readdatavalid, ib_m1.readdatavalid} !== 2'b00) begin
        n_err++; $display("FAIL rst_flush[%0d]: got %b, required 00", i, {ib_m0.readdatavalid, ib_m1.readdatavalid});
      end
      step();
    end
    set_m(1'b1, 1'b0, 1'b1, 1'b0, 14'h00A, '0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 14'h00B, '0);
    qb.push_back('{cyc + 3, 1'b0, init_word(14'h00A)});
    @(negedge clk);
    n_cmp++;
    if ({ib_m0.waitrequest, ib_m1.waitrequest} !== 2'b01) begin
      n_err++; $display("FAIL rst_prio_m0: got wreq=%b, required 01", {ib_m0.waitrequest, ib_m1.waitrequest});
    end
    step();
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    qb.push_back('{cyc + 3, 1'b1, init_word(14'h00B)});
    step();
    idle(1'b1);
    repeat (4) step();
    n_cmp++;
    if (stall_b !== 4'd1 || qb.size() != 0) begin
      n_err++; $display("FAIL rst_after: got stall=%0d pending=%0d, required 1 0", stall_b, qb.size());
    end
  endtask

  task automatic test_saturate();
    logic w;
    int   expv;
    step();
    set_m(1'b1, 1'b0, 1'b1, 1'b0, 14'h00C, '0);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 14'h00D, '0);
    // Counter starts at 1 (one contended cycle earlier); m1 was accepted last.
    for (int i = 0; i < 20; i++) begin
      w = (i % 2 == 1);
      qb.push_back('{cyc + 3, w, init_word(w ? 14'h00D : 14'h00C)});
      expv = (1 + i > 15) ? 15 : 1 + i;
      @(negedge clk);
      n_cmp++;
      if (stall_b !== 4'(expv)) begin
        n_err++; $display("FAIL sat_count[%0d]: got %0d, required %0d", i, stall_b, expv);
      end
      step();
    end
    idle(1'b1);
    repeat (4) step();
    n_cmp++;
    if (stall_b !== 4'hF || qb.size() != 0) begin
      n_err++; $display("FAIL sat_hold: got stall=%h pending=%0d, required F 0", stall_b, qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_interleave_rl3();
    test_reset_midflight();
    test_saturate();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
